history_bank: RTL and testbench

HISTORY_BANK -- requirements
Module: history_bank

---
 rtl/history_bank.sv | 171 +++++++++++++++++
 tb/tb_history_bank.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/history_bank.sv
// history_bank: byte-enabled history line store with per-byte written flags and a copy-read engine.
// Latency: handshake to rsp_valid is 3 cycles minimum; a request waits until all requested bytes are written.
// Backpressure: writes and clears are always accepted; rd_req_ready is high only in IDLE; rsp_* has no backpressure.
//
// Ports:
//   clk, rst_n                   - single clock, asynchronous active-low reset
//   wr_valid/wr_address/wr_data/wr_byte_valid - byte-enabled line write, sets written flags
//   clr_valid/clr_address        - zero the written flags of one line (line recycled)
//   rd_req_valid/rd_req_ready/rd_req_address/rd_req_mask/rd_req_dest - copy-read request
//   rsp_valid/rsp_data/rsp_address/rsp_byte_valid - one-cycle response pulse, values held afterwards
//   stall_cycles                 - cycles spent waiting for data (counter present only with
//                                  HISTORY_BANK_STALL_CNT_EN defined, otherwise tied to 0)
module history_bank #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       wr_data,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [7:0]        wr_byte_valid,
  input  logic              wr_valid,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_address,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_address,
  input  logic [7:0]        rd_req_mask,
  input  logic [ADDR_W-1:0] rd_req_dest,
  output logic [63:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_address,
  output logic [7:0]        rsp_byte_valid,
  output logic              rsp_valid,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [63:0]       mem   [DEPTH];
  logic [7:0]        flags [DEPTH];

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dest_q;
  logic [7:0]        mask_q;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] clr_idx;
  logic              wait_ok;

  // Fold any address into 0..DEPTH-1; free when DEPTH is a power of two.
  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % DEPTH);
  endfunction

  assign wr_idx  = wrap(wr_address);
  assign clr_idx = wrap(clr_address);

  // Line storage: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_byte_valid[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Written flags. A clear and a write hitting the same line in one cycle
  // behave as clear-then-write, so the write's bytes survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        flags[i] <= '0;
      end
    end else begin
      if (clr_valid) begin
        flags[clr_idx] <= '0;
      end
      if (wr_valid) begin
        flags[wr_idx] <= ((clr_valid && (clr_idx == wr_idx)) ? 8'h00 : flags[wr_idx])
                         | wr_byte_valid;
      end
    end
  end

  // Uses the registered flags, so a write landing this cycle is seen next cycle.
  assign wait_ok = ((flags[src_q] & mask_q) == mask_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_req_ready = 1'b0;
    case (state)
      IDLE: begin
        rd_req_ready = 1'b1;
        if (rd_req_valid) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_ok) begin
          state_nxt = READ;
        end
      end
      READ:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dest_q <= '0;
      mask_q <= '0;
    end else if ((state == IDLE) && rd_req_valid) begin
      src_q  <= wrap(rd_req_address);
      dest_q <= rd_req_dest;
      mask_q <= rd_req_mask;
    end
  end

  // Memory read in READ; nonblocking semantics give read-first behaviour
  // against a write to the same line on the same edge. Outputs hold until
  // the next READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data       <= '0;
      rsp_address    <= '0;
      rsp_byte_valid <= '0;
    end else if (state == READ) begin
      rsp_data       <= mem[src_q];
      rsp_address    <= dest_q;
      rsp_byte_valid <= mask_q;
    end
  end

  assign rsp_valid = (state == RESP);

`ifdef HISTORY_BANK_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state == WAIT) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_history_bank.sv
// Self-checking bench for history_bank: directed scenarios plus randomized
// requests, checked against a line/flag array model that predicts, cycle by
// cycle, when each request's bytes become available.
module tb_history_bank;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       wr_data;
  logic [ADDR_W-1:0] wr_address;
  logic [7:0]        wr_byte_valid;
  logic              wr_valid;
  logic              clr_valid;
  logic [ADDR_W-1:0] clr_address;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_address;
  logic [7:0]        rd_req_mask;
  logic [ADDR_W-1:0] rd_req_dest;
  logic [63:0]       rsp_data;
  logic [ADDR_W-1:0] rsp_address;
  logic [7:0]        rsp_byte_valid;
  logic              rsp_valid;
  logic [15:0]       stall_cycles;

  history_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_address     (wr_address),
    .wr_byte_valid  (wr_byte_valid),
    .wr_valid       (wr_valid),
    .clr_valid      (clr_valid),
    .clr_address    (clr_address),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_address (rd_req_address),
    .rd_req_mask    (rd_req_mask),
    .rd_req_dest    (rd_req_dest),
    .rsp_data       (rsp_data),
    .rsp_address    (rsp_address),
    .rsp_byte_valid (rsp_byte_valid),
    .rsp_valid      (rsp_valid),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [8:0]  addr;
    logic [7:0]  bv;
    logic [63:0] data;
    bit          clr;
    logic [8:0]  caddr;
  } op_t;

  // Reference model
  logic [63:0] mem_m   [DEPTH];
  logic [7:0]  flags_m [DEPTH];
  int          stall_exp;
  op_t         sched[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [15:0] stall_ref();
`ifdef HISTORY_BANK_STALL_CNT_EN
    return (stall_exp > 16'hFFFF) ? 16'hFFFF : 16'(stall_exp);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic op_t mk(input int cyc, input bit wr, input logic [8:0] addr,
                             input logic [7:0] bv, input logic [63:0] data,
                             input bit clr, input logic [8:0] caddr);
    op_t o;
    o.cyc = cyc; o.wr = wr; o.addr = addr; o.bv = bv; o.data = data;
    o.clr = clr; o.caddr = caddr;
    return o;
  endfunction

  // Drive one write/clear for the current cycle and apply it to the model
  // (clear first, then the written bytes).
  task automatic drive_op(input op_t o);
    wr_valid      = o.wr;
    wr_address    = o.addr;
    wr_byte_valid = o.bv;
    wr_data       = o.data;
    clr_valid     = o.clr;
    clr_address   = o.caddr;
    if (o.clr) flags_m[o.caddr] = 8'h00;
    if (o.wr) begin
      for (int b = 0; b < 8; b++)
        if (o.bv[b]) mem_m[o.addr][8*b +: 8] = o.data[8*b +: 8];
      flags_m[o.addr] = flags_m[o.addr] | o.bv;
    end
  endtask

  task automatic idle_op(input op_t o);
    drive_op(o);
    @(negedge clk);
    wr_valid  = 1'b0;
    clr_valid = 1'b0;
  endtask

  // Issue one request and follow it to its response. Cycle k counts from the
  // handshake edge; the model decides the first cycle whose flags cover the
  // mask (pass), the response is due at pass+2 and the data is the line as
  // it stood during pass+1, before that cycle's writes.
  task automatic run_req(input logic [8:0] src, input logic [7:0] mask,
                         input logic [8:0] dest, input bit hold);
    int k, pass, guard;
    bit done;
    logic [63:0] exp_data;
    rd_req_valid   = 1'b1;
    rd_req_address = src;
    rd_req_mask    = mask;
    rd_req_dest    = dest;
    guard = 0;
    while (rd_req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      wr_valid = 1'b0; clr_valid = 1'b0;
      guard++;
    end
    chk("req_ready_idle", rd_req_ready, 1'b1);
    @(negedge clk);
    if (!hold) rd_req_valid = 1'b0;
    k = 1; pass = -1; done = 1'b0; exp_data = '0;
    while (k < TMO) begin
      wr_valid = 1'b0; clr_valid = 1'b0;
      if (pass < 0 && ((flags_m[src] & mask) == mask)) begin
        pass = k;
        stall_exp += pass;
      end
      if (pass >= 0 && k == pass + 1) exp_data = mem_m[src];
      chk("rsp_valid_timing", rsp_valid, (pass >= 0 && k == pass + 2));
      chk("req_ready_busy", rd_req_ready, 1'b0);
      if (pass >= 0 && k == pass + 2) begin
        if (mask != 8'h00)
          chk("rsp_data", rsp_data & expand(mask), exp_data & expand(mask));
        chk("rsp_address", rsp_address, dest);
        chk("rsp_byte_valid", rsp_byte_valid, mask);
        chk("stall_cycles", stall_cycles, stall_ref());
        done = 1'b1;
        break;
      end
      foreach (sched[i]) if (sched[i].cyc == k) drive_op(sched[i]);
      @(negedge clk);
      k++;
    end
    chk("rsp_seen", done, 1'b1);
    sched.delete();
  endtask

  // Response outputs must stay put and rsp_valid low while idle.
  task automatic idle_check(input int n);
    logic [63:0] d;
    logic [8:0]  a;
    logic [7:0]  m;
    d = rsp_data; a = rsp_address; m = rsp_byte_valid;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_no_rsp", rsp_valid, 1'b0);
      chk("idle_ready", rd_req_ready, 1'b1);
    end
    chk("hold_rsp_data", rsp_data, d);
    chk("hold_rsp_address", rsp_address, a);
    chk("hold_rsp_bv", rsp_byte_valid, m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  src, dest, ln;
    logic [7:0]  mask, missing;
    logic [63:0] d;
    int          mode;

    for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; flags_m[i] = '0; end
    stall_exp = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_address = '0; wr_byte_valid = '0; wr_data = '0;
    clr_valid = 1'b0; clr_address = '0;
    rd_req_valid = 1'b0; rd_req_address = '0; rd_req_mask = '0; rd_req_dest = '0;

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_ready", rd_req_ready, 1'b1);
    chk("reset_rsp_data", rsp_data, 64'h0);
    chk("reset_rsp_address", rsp_address, 9'h0);
    chk("reset_rsp_bv", rsp_byte_valid, 8'h0);
    chk("reset_stall", stall_cycles, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic full-line copy
    idle_op(mk(0, 1, 9'd5, 8'hFF, 64'h0123456789ABCDEF, 0, 9'd0));
    run_req(9'd5, 8'hFF, 9'd9, 0);
    chk("basic_data_full", rsp_data, 64'h0123456789ABCDEF);
    idle_check(3);

    // Stall until two partial writes complete the mask
    sched.push_back(mk(4, 1, 9'd7, 8'h03, 64'h1111_2222_3333_4444, 0, 9'd0));
    sched.push_back(mk(10, 1, 9'd7, 8'h0C, 64'h5555_6666_7777_8888, 0, 9'd0));
    run_req(9'd7, 8'h0F, 9'd17, 0);

    // Same-cycle clear and write on line 3
    idle_op(mk(0, 1, 9'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0, 9'd0));
    idle_op(mk(0, 1, 9'd3, 8'hF0, 64'h9988_7766_5544_3322, 1, 9'd3));
    run_req(9'd3, 8'hF0, 9'd30, 0);
    sched.push_back(mk(8, 1, 9'd3, 8'h0F, 64'h0000_0000_1357_9BDF, 0, 9'd0));
    run_req(9'd3, 8'hFF, 9'd31, 0);

    // Byte merge across two writes
    idle_op(mk(0, 1, 9'd2, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 9'd0));
    idle_op(mk(0, 1, 9'd2, 8'hF0, 64'hBBBBBBBBBBBBBBBB, 0, 9'd0));
    run_req(9'd2, 8'hFF, 9'd2, 0);
    chk("merge_data", rsp_data, 64'hBBBBBBBBAAAAAAAA);

    // Zero mask on an unwritten line passes immediately
    idle_op(mk(0, 0, 9'd0, 8'h00, 64'h0, 1, 9'd100));
    run_req(9'd100, 8'h00, 9'd101, 0);

    // Read-first: write to the source line in the READ cycle
    sched.push_back(mk(2, 1, 9'd5, 8'hFF, 64'hFEDC_BA98_7654_3210, 0, 9'd0));
    run_req(9'd5, 8'hFF, 9'd55, 0);
    chk("read_first_old", rsp_data, 64'h0123456789ABCDEF);
    run_req(9'd5, 8'hFF, 9'd56, 0);

    // Address extremes
    idle_op(mk(0, 1, 9'd511, 8'hFF, 64'h5A5A_0F0F_A5A5_F0F0, 0, 9'd0));
    idle_op(mk(0, 1, 9'd0, 8'h81, 64'h7700_0000_0000_0066, 0, 9'd0));
    run_req(9'd511, 8'hFF, 9'd0, 0);
    run_req(9'd0, 8'h81, 9'd511, 0);

    // Back-to-back requests with valid held high
    idle_op(mk(0, 1, 9'd40, 8'hFF, 64'h4040_4040_4040_4040, 0, 9'd0));
    idle_op(mk(0, 1, 9'd41, 8'h3C, 64'h0041_4141_4141_0000, 0, 9'd0));
    run_req(9'd40, 8'hFF, 9'd140, 1);
    run_req(9'd41, 8'h3C, 9'd141, 1);
    run_req(9'd40, 8'h0F, 9'd142, 0);
    idle_check(4);

    // Randomized requests
    for (int it = 0; it < 30; it++) begin
      src  = 9'($urandom_range(0, DEPTH - 1));
      dest = 9'($urandom_range(0, DEPTH - 1));
      ln   = 9'($urandom_range(0, DEPTH - 1));
      idle_op(mk(0, 1, src, 8'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0) ? src : ln));
      if ($urandom_range(0, 1) == 1)
        idle_op(mk(0, 1, src, 8'($urandom), {$urandom, $urandom}, 0, 9'd0));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        mask = 8'($urandom) & flags_m[src];
      end else if (mode == 1) begin
        mask    = 8'($urandom);
        missing = mask & ~flags_m[src];
        if (missing != 8'h00)
          sched.push_back(mk($urandom_range(1, 6), 1, src, missing | 8'($urandom),
                             {$urandom, $urandom}, 0, 9'd0));
      end else begin
        mask = 8'($urandom) & flags_m[src];
        sched.push_back(mk(2, 1, src, 8'($urandom), {$urandom, $urandom}, 0, 9'd0));
      end
      run_req(src, mask, dest, 0);
    end

    // Reset while a request sits in WAIT
    idle_op(mk(0, 0, 9'd0, 8'h00, 64'h0, 1, 9'd200));
    rd_req_valid = 1'b1; rd_req_address = 9'd200; rd_req_mask = 8'h01; rd_req_dest = 9'd77;
    for (int g = 0; g < 20 && rd_req_ready !== 1'b1; g++) @(negedge clk);
    @(negedge clk);
    rd_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", rd_req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_ready", rd_req_ready, 1'b1);
    chk("arst_rsp_data", rsp_data, 64'h0);
    chk("arst_rsp_address", rsp_address, 9'h0);
    chk("arst_rsp_bv", rsp_byte_valid, 8'h0);
    chk("arst_stall", stall_cycles, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) flags_m[i] = '0;
    stall_exp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 1'b0);
      chk("post_reset_ready", rd_req_ready, 1'b1);
    end
    // Line 5 was fully written before reset; its flags must now be zero.
    sched.push_back(mk(5, 1, 9'd5, 8'hFF, 64'h0F1E_2D3C_4B5A_6978, 0, 9'd0));
    run_req(9'd5, 8'hFF, 9'd6, 0);
    d = 64'h0F1E_2D3C_4B5A_6978;
    chk("post_reset_data", rsp_data, d);
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
